// File: rtl/ethernet_pkg.sv
// Shared types and helpers for the ethernet controller host-side MMIO bridge.
// Byte-lane masking and alignment checks live here so other host-facing blocks can reuse them.
package ethernet_pkg;

  localparam int unsigned eth_data_width_lp = 64;

  typedef enum logic [1:0] {
    e_bridge_idle,
    e_bridge_issue,
    e_bridge_wait_rd,
    e_bridge_resp
  } ethernet_bridge_state_e;

  typedef enum logic [1:0] {
    e_size_1B,
    e_size_2B,
    e_size_4B,
    e_size_8B
  } ethernet_op_size_e;

  function automatic logic [eth_data_width_lp-1:0] size_mask(input logic [1:0] size);
    logic [eth_data_width_lp-1:0] mask;
    case (ethernet_op_size_e'(size))
      e_size_1B: mask = 64'h0000_0000_0000_00FF;
      e_size_2B: mask = 64'h0000_0000_0000_FFFF;
      e_size_4B: mask = 64'h0000_0000_FFFF_FFFF;
      default:   mask = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
    return mask;
  endfunction

  function automatic logic misaligned(input logic [15:0] addr, input logic [1:0] size);
    logic bad;
    case (ethernet_op_size_e'(size))
      e_size_1B: bad = 1'b0;
      e_size_2B: bad = addr[0];
      e_size_4B: bad = |addr[1:0];
      default:   bad = |addr[2:0];
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/ethernet_mmio_bridge.sv
// Host-side MMIO front end of the ethernet controller: one request in flight, one strobe per
// request, one response per request, with a timeout on reads that never return data.
module ethernet_mmio_bridge
  import ethernet_pkg::*;
#(
  parameter int data_width_p     = 64,
  parameter int timeout_p        = 64,
  parameter int timeout_width_lp = $clog2(timeout_p + 1)
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,

  input  logic                    req_v_i,
  output logic                    req_ready_o,
  input  logic                    req_we_i,
  input  logic [15:0]             req_addr_i,
  input  logic [1:0]              req_size_i,
  input  logic [data_width_p-1:0] req_data_i,

  output logic                    resp_v_o,
  input  logic                    resp_ready_i,
  output logic [data_width_p-1:0] resp_data_o,
  output logic                    resp_err_o,

  output logic [15:0]             ctrl_addr_o,
  output logic                    ctrl_write_en_o,
  output logic                    ctrl_read_en_o,
  output logic [1:0]              ctrl_op_size_o,
  output logic [data_width_p-1:0] ctrl_write_data_o,
  input  logic [data_width_p-1:0] ctrl_read_data_i,
  input  logic                    ctrl_read_data_v_i
);

  localparam logic [timeout_width_lp-1:0] timeout_last_lp = timeout_width_lp'(timeout_p - 1);

  ethernet_bridge_state_e state_q, state_d;

  logic [15:0]               ctrl_addr_q,  ctrl_addr_d;
  logic [1:0]                ctrl_size_q,  ctrl_size_d;
  logic [data_width_p-1:0]   ctrl_wdata_q, ctrl_wdata_d;
  logic                      we_q,         we_d;
  logic [timeout_width_lp-1:0] cnt_q,      cnt_d;
  logic [data_width_p-1:0]   resp_data_q,  resp_data_d;
  logic                      resp_err_q,   resp_err_d;

  logic [eth_data_width_lp-1:0] lane_mask_full;
  logic [data_width_p-1:0]      lane_mask;
  logic [timeout_width_lp-1:0]  cnt_inc;

  assign lane_mask_full = size_mask(ctrl_size_q);
  assign lane_mask      = lane_mask_full[data_width_p-1:0];
  assign cnt_inc        = cnt_q + timeout_width_lp'(1);

  always_comb begin
    state_d         = state_q;
    ctrl_addr_d     = ctrl_addr_q;
    ctrl_size_d     = ctrl_size_q;
    ctrl_wdata_d    = ctrl_wdata_q;
    we_d            = we_q;
    cnt_d           = cnt_q;
    resp_data_d     = resp_data_q;
    resp_err_d      = resp_err_q;
    req_ready_o     = (state_q == e_bridge_idle);
    ctrl_write_en_o = 1'b0;
    ctrl_read_en_o  = 1'b0;

    case (state_q)
      e_bridge_idle: begin
        if (req_v_i) begin
          // Misaligned requests never reach the controller, so its port registers keep their values.
          if (misaligned(req_addr_i, req_size_i)) begin
            state_d     = e_bridge_resp;
            resp_err_d  = 1'b1;
            resp_data_d = '1;
          end else begin
            state_d      = e_bridge_issue;
            ctrl_addr_d  = req_addr_i;
            ctrl_size_d  = req_size_i;
            ctrl_wdata_d = req_data_i;
            we_d         = req_we_i;
          end
        end
      end

      e_bridge_issue: begin
        ctrl_write_en_o = we_q;
        ctrl_read_en_o  = !we_q;
        if (we_q) begin
          state_d     = e_bridge_resp;
          resp_err_d  = 1'b0;
          resp_data_d = '0;
        end else begin
          state_d = e_bridge_wait_rd;
          cnt_d   = '0;
        end
      end

      e_bridge_wait_rd: begin
        // Returned data takes priority over a timeout expiring in the same cycle.
        if (ctrl_read_data_v_i) begin
          state_d     = e_bridge_resp;
          resp_err_d  = 1'b0;
          resp_data_d = ctrl_read_data_i & lane_mask;
        end else if (cnt_inc == timeout_last_lp) begin
          state_d     = e_bridge_resp;
          resp_err_d  = 1'b1;
          resp_data_d = '1;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      e_bridge_resp: begin
        if (resp_ready_i) begin
          state_d     = e_bridge_idle;
          resp_err_d  = 1'b0;
          resp_data_d = '0;
        end
      end

      default: state_d = e_bridge_idle;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= e_bridge_idle;
      ctrl_addr_q  <= '0;
      ctrl_size_q  <= '0;
      ctrl_wdata_q <= '0;
      we_q         <= 1'b0;
      cnt_q        <= '0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      ctrl_addr_q  <= ctrl_addr_d;
      ctrl_size_q  <= ctrl_size_d;
      ctrl_wdata_q <= ctrl_wdata_d;
      we_q         <= we_d;
      cnt_q        <= cnt_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign resp_v_o          = (state_q == e_bridge_resp);
  assign resp_data_o       = resp_data_q;
  assign resp_err_o        = resp_err_q;
  assign ctrl_addr_o       = ctrl_addr_q;
  assign ctrl_op_size_o    = ctrl_size_q;
  assign ctrl_write_data_o = ctrl_wdata_q;

endmodule

// File: tb/tb_ethernet_mmio_bridge.sv
// Directed bench for ethernet_mmio_bridge: writes, reads, misalignment, timeout, backpressure
// and mid-transaction reset, each against hand-computed expected values.
module tb_ethernet_mmio_bridge;

  localparam int dw = 64;

  logic          clk;
  logic          reset_n;
  logic          req_v;
  logic          req_ready;
  logic          req_we;
  logic [15:0]   req_addr;
  logic [1:0]    req_size;
  logic [dw-1:0] req_data;
  logic          resp_v;
  logic          resp_ready;
  logic [dw-1:0] resp_data;
  logic          resp_err;
  logic [15:0]   ctrl_addr;
  logic          ctrl_we;
  logic          ctrl_re;
  logic [1:0]    ctrl_size;
  logic [dw-1:0] ctrl_wdata;
  logic [dw-1:0] ctrl_rdata;
  logic          ctrl_rdata_v;

  int n_checks;
  int n_fail;

  ethernet_mmio_bridge #(.data_width_p(dw), .timeout_p(64)) dut (
    .clk_i              (clk),
    .reset_n_i          (reset_n),
    .req_v_i            (req_v),
    .req_ready_o        (req_ready),
    .req_we_i           (req_we),
    .req_addr_i         (req_addr),
    .req_size_i         (req_size),
    .req_data_i         (req_data),
    .resp_v_o           (resp_v),
    .resp_ready_i       (resp_ready),
    .resp_data_o        (resp_data),
    .resp_err_o         (resp_err),
    .ctrl_addr_o        (ctrl_addr),
    .ctrl_write_en_o    (ctrl_we),
    .ctrl_read_en_o     (ctrl_re),
    .ctrl_op_size_o     (ctrl_size),
    .ctrl_write_data_o  (ctrl_wdata),
    .ctrl_read_data_i   (ctrl_rdata),
    .ctrl_read_data_v_i (ctrl_rdata_v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one request for one cycle; returns in the cycle after acceptance (T+1).
  task automatic send(input logic we, input logic [15:0] addr, input logic [1:0] size,
                      input logic [63:0] data);
    check("req_ready_before_send", {63'd0, req_ready}, 64'd1);
    req_v    = 1'b1;
    req_we   = we;
    req_addr = addr;
    req_size = size;
    req_data = data;
    tick();
    req_v    = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, {63'd0, req_ready}, 64'd1);
    check({tag, "_resp_v"},    {63'd0, resp_v},    64'd0);
    check({tag, "_resp_err"},  {63'd0, resp_err},  64'd0);
    check({tag, "_resp_data"}, resp_data,          64'd0);
    check({tag, "_ctrl_en"},   {62'd0, ctrl_we, ctrl_re}, 64'd0);
    check({tag, "_ctrl_addr"}, {48'd0, ctrl_addr}, 64'd0);
    check({tag, "_ctrl_size"}, {62'd0, ctrl_size}, 64'd0);
    check({tag, "_ctrl_wdata"}, ctrl_wdata,        64'd0);
  endtask

  initial begin
    int n;
    n_checks     = 0;
    n_fail       = 0;
    reset_n      = 1'b0;
    req_v        = 1'b0;
    req_we       = 1'b0;
    req_addr     = '0;
    req_size     = '0;
    req_data     = '0;
    resp_ready   = 1'b1;
    ctrl_rdata   = '0;
    ctrl_rdata_v = 1'b0;

    #1;
    check_reset_outputs("reset");
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    check_reset_outputs("post_reset");

    // 8B write
    send(1'b1, 16'h0010, 2'd3, 64'h1122_3344_5566_7788);
    check("wr_we_T1",    {63'd0, ctrl_we},    64'd1);
    check("wr_re_T1",    {63'd0, ctrl_re},    64'd0);
    check("wr_addr_T1",  {48'd0, ctrl_addr},  64'h0010);
    check("wr_size_T1",  {62'd0, ctrl_size},  64'd3);
    check("wr_data_T1",  ctrl_wdata,          64'h1122_3344_5566_7788);
    check("wr_ready_T1", {63'd0, req_ready},  64'd0);
    check("wr_respv_T1", {63'd0, resp_v},     64'd0);
    tick();
    check("wr_we_T2",    {63'd0, ctrl_we},    64'd0);
    check("wr_respv_T2", {63'd0, resp_v},     64'd1);
    check("wr_err_T2",   {63'd0, resp_err},   64'd0);
    check("wr_rdata_T2", resp_data,           64'd0);
    check("wr_addr_hold", {48'd0, ctrl_addr}, 64'h0010);
    tick();
    check("wr_respv_T3", {63'd0, resp_v},     64'd0);
    check("wr_ready_T3", {63'd0, req_ready},  64'd1);

    // 2B read
    send(1'b0, 16'h0802, 2'd1, 64'd0);
    check("rd2_re_T1",   {63'd0, ctrl_re},    64'd1);
    check("rd2_we_T1",   {63'd0, ctrl_we},    64'd0);
    check("rd2_addr_T1", {48'd0, ctrl_addr},  64'h0802);
    check("rd2_size_T1", {62'd0, ctrl_size},  64'd1);
    tick();
    ctrl_rdata   = 64'hDEAD_BEEF_CAFE_1234;
    ctrl_rdata_v = 1'b1;
    check("rd2_re_T2",    {63'd0, ctrl_re},   64'd0);
    check("rd2_respv_T2", {63'd0, resp_v},    64'd0);
    tick();
    ctrl_rdata_v = 1'b0;
    check("rd2_respv_T3", {63'd0, resp_v},    64'd1);
    check("rd2_data_T3",  resp_data,          64'h1234);
    check("rd2_err_T3",   {63'd0, resp_err},  64'd0);
    tick();
    check("rd2_ready_T4", {63'd0, req_ready}, 64'd1);

    // Misaligned 4B read
    send(1'b0, 16'h0006, 2'd2, 64'd0);
    check("mis_re_T1",    {63'd0, ctrl_re},   64'd0);
    check("mis_respv_T1", {63'd0, resp_v},    64'd1);
    check("mis_err_T1",   {63'd0, resp_err},  64'd1);
    check("mis_data_T1",  resp_data,          64'hFFFF_FFFF_FFFF_FFFF);
    check("mis_addr_hold", {48'd0, ctrl_addr}, 64'h0802);
    tick();
    check("mis_ready_T2", {63'd0, req_ready}, 64'd1);

    // Read timeout with a silent controller
    send(1'b0, 16'h0100, 2'd3, 64'd0);
    check("to_re_strobe", {63'd0, ctrl_re}, 64'd1);
    n = 0;
    while (!resp_v && n < 200) begin
      tick();
      n++;
    end
    check("to_latency",  64'(n),             64'd64);
    check("to_err",      {63'd0, resp_err},  64'd1);
    check("to_data",     resp_data,          64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    ctrl_rdata   = 64'h0BAD_0BAD_0BAD_0BAD;
    ctrl_rdata_v = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("late_respv", {63'd0, resp_v},    64'd0);
      check("late_ready", {63'd0, req_ready}, 64'd1);
    end
    ctrl_rdata_v = 1'b0;
    check("late_resp_data", resp_data, 64'd0);
    send(1'b1, 16'h0040, 2'd2, 64'h0000_0000_A5A5_A5A5);
    check("post_to_we",    {63'd0, ctrl_we},   64'd1);
    check("post_to_wdata", ctrl_wdata,         64'h0000_0000_A5A5_A5A5);
    tick();
    check("post_to_respv", {63'd0, resp_v},    64'd1);
    check("post_to_err",   {63'd0, resp_err},  64'd0);
    tick();

    // Response backpressure on a 1B read
    resp_ready = 1'b0;
    send(1'b0, 16'h0003, 2'd0, 64'd0);
    tick();
    ctrl_rdata   = 64'h1234_5678_90AB_CDEF;
    ctrl_rdata_v = 1'b1;
    tick();
    ctrl_rdata_v = 1'b0;
    ctrl_rdata   = 64'hFFFF_FFFF_FFFF_FFFF;
    for (int i = 0; i < 10; i++) begin
      check("bp_respv", {63'd0, resp_v},    64'd1);
      check("bp_data",  resp_data,          64'hEF);
      check("bp_err",   {63'd0, resp_err},  64'd0);
      check("bp_ready", {63'd0, req_ready}, 64'd0);
      tick();
    end
    resp_ready = 1'b1;
    check("bp_respv_hs", {63'd0, resp_v}, 64'd1);
    tick();
    check("bp_idle_ready", {63'd0, req_ready}, 64'd1);
    check("bp_idle_respv", {63'd0, resp_v},    64'd0);

    // Reset pulsed during WAIT_RD
    send(1'b0, 16'h0020, 2'd2, 64'd0);
    tick();
    #2 reset_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    @(posedge clk);
    #1 reset_n = 1'b1;
    ctrl_rdata   = 64'h5555_5555_5555_5555;
    ctrl_rdata_v = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      ctrl_rdata_v = 1'b0;
      check("rst_no_resp", {63'd0, resp_v}, 64'd0);
    end

    // Following 4B read: upper half zeroed, bit 31 set but not sign-extended
    send(1'b0, 16'h0804, 2'd2, 64'd0);
    check("rd4_re_T1", {63'd0, ctrl_re}, 64'd1);
    tick();
    ctrl_rdata   = 64'h8899_AABB_CCDD_EEFF;
    ctrl_rdata_v = 1'b1;
    tick();
    ctrl_rdata_v = 1'b0;
    check("rd4_respv", {63'd0, resp_v},   64'd1);
    check("rd4_data",  resp_data,         64'h0000_0000_CCDD_EEFF);
    check("rd4_err",   {63'd0, resp_err}, 64'd0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
